// File: rtl/key_progress.sv
// Key/door progress tracker for STAGE1: follows the player's box against the
// current target, advances key_find on interact rises, and pulses pickup/stage_clear.
module key_progress #(
  parameter logic [23:0] COOLDOWN = 24'd1_000_000,
  parameter int unsigned PLAYER_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state,
  input  logic [8:0] player_x,
  input  logic [8:0] player_y,
  input  logic       interact,
  output logic [1:0] key_find,
  output logic       pickup,
  output logic       stage_clear,
  output logic       busy
);

  localparam int unsigned CNT_W = 24;
  localparam int unsigned CRD_W = 10;
  localparam logic [3:0]  STAGE1 = 4'd2;
  localparam logic [8:0]  X_MAX = 9'd319;
  localparam logic [8:0]  Y_MAX = 9'd239;

  typedef enum logic [1:0] {
    NONE       = 2'd0,
    FIND_KEY   = 2'd1,
    FIND_LIGHT = 2'd2,
    FIND_DOOR  = 2'd3
  } prog_e;

  prog_e             prog_q, prog_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              interact_q, interact_d;
  logic              pickup_q, pickup_d;
  logic              stage_clear_q, stage_clear_d;
  logic              busy_q, busy_d;

  logic [CRD_W-1:0]  tx0_c, tx1_c, ty0_c, ty1_c;
  logic [CRD_W-1:0]  px_c, py_c, px_end_c, py_end_c;
  logic              in_range_c, overlap_c, rise_c, accept_c;

  // Target box drawn for the current progress code
  always_comb begin
    tx0_c = CRD_W'(65);
    tx1_c = CRD_W'(84);
    ty0_c = CRD_W'(35);
    ty1_c = CRD_W'(54);
    case (prog_q)
      NONE: begin
        tx0_c = CRD_W'(65);
        tx1_c = CRD_W'(84);
        ty0_c = CRD_W'(35);
        ty1_c = CRD_W'(54);
      end
      FIND_KEY: begin
        tx0_c = CRD_W'(235);
        tx1_c = CRD_W'(254);
        ty0_c = CRD_W'(35);
        ty1_c = CRD_W'(54);
      end
      FIND_LIGHT: begin
        tx0_c = CRD_W'(235);
        tx1_c = CRD_W'(254);
        ty0_c = CRD_W'(205);
        ty1_c = CRD_W'(224);
      end
      FIND_DOOR: begin
        tx0_c = CRD_W'(145);
        tx1_c = CRD_W'(174);
        ty0_c = CRD_W'(205);
        ty1_c = CRD_W'(234);
      end
      default: ;
    endcase
  end

  // Overlap against the target; 10-bit sums so the far edge cannot wrap
  always_comb begin
    px_c       = {1'b0, player_x};
    py_c       = {1'b0, player_y};
    px_end_c   = px_c + CRD_W'(PLAYER_W - 1);
    py_end_c   = py_c + CRD_W'(PLAYER_W - 1);
    in_range_c = (player_x <= X_MAX) && (player_y <= Y_MAX);
    overlap_c  = in_range_c &&
                 (px_c <= tx1_c) && (px_end_c >= tx0_c) &&
                 (py_c <= ty1_c) && (py_end_c >= ty0_c);
  end

  assign rise_c   = interact & ~interact_q;
  assign accept_c = (state == STAGE1) && rise_c && overlap_c && (cnt_q == '0);

  // Next-state and registered-output logic
  always_comb begin
    prog_d        = prog_q;
    cnt_d         = (cnt_q != '0) ? (cnt_q - CNT_W'(1)) : '0;
    interact_d    = interact;
    pickup_d      = 1'b0;
    stage_clear_d = 1'b0;

    if (state != STAGE1) begin
      prog_d = NONE;
      cnt_d  = '0;
    end else if (accept_c) begin
      cnt_d = COOLDOWN;
      if (prog_q == FIND_DOOR) begin
        stage_clear_d = 1'b1;
      end else begin
        pickup_d = 1'b1;
        prog_d   = prog_e'(prog_q + 2'd1);
      end
    end

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prog_q        <= NONE;
      cnt_q         <= '0;
      interact_q    <= 1'b0;
      pickup_q      <= 1'b0;
      stage_clear_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      prog_q        <= prog_d;
      cnt_q         <= cnt_d;
      interact_q    <= interact_d;
      pickup_q      <= pickup_d;
      stage_clear_q <= stage_clear_d;
      busy_q        <= busy_d;
    end
  end

  assign key_find    = prog_q;
  assign pickup      = pickup_q;
  assign stage_clear = stage_clear_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_key_progress.sv
// Bench for key_progress: directed scenarios plus random walk, checked every
// cycle against a behavioural model of the progress rules.
module tb_key_progress;

  localparam int CD = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] state;
  logic [8:0] player_x;
  logic [8:0] player_y;
  logic       interact;
  logic [1:0] key_find;
  logic       pickup;
  logic       stage_clear;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  key_progress #(.COOLDOWN(24'd8), .PLAYER_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .player_x(player_x),
    .player_y(player_y), .interact(interact), .key_find(key_find),
    .pickup(pickup), .stage_clear(stage_clear), .busy(busy)
  );

  always #5 clk = ~clk;

  // Target boxes in progress order: key1, key2, key3, door
  int bx0[4] = '{65, 235, 235, 145};
  int bx1[4] = '{84, 254, 254, 174};
  int by0[4] = '{35, 35, 205, 205};
  int by1[4] = '{54, 54, 224, 234};

  int m_kf = 0, m_cnt = 0;
  bit m_prev = 0, m_pick = 0, m_clear = 0;

  function automatic bit hits(int t, int px, int py);
    if (px > 319 || py > 239) return 1'b0;
    return (px <= bx1[t]) && (px + 15 >= bx0[t]) && (py <= by1[t]) && (py + 15 >= by0[t]);
  endfunction

  // Reference model: what the outputs must be after each edge
  always @(posedge clk) begin
    bit rise, acc;
    if (!rst_n) begin
      m_kf = 0; m_cnt = 0; m_prev = 0; m_pick = 0; m_clear = 0;
    end else begin
      rise    = interact && !m_prev;
      m_prev  = interact;
      m_pick  = 0;
      m_clear = 0;
      if (state != 4'd2) begin
        m_kf = 0; m_cnt = 0;
      end else begin
        acc = rise && hits(m_kf, int'(player_x), int'(player_y)) && (m_cnt == 0);
        if (m_cnt > 0) m_cnt = m_cnt - 1;
        if (acc) begin
          m_cnt = CD;
          if (m_kf < 3) begin m_kf = m_kf + 1; m_pick = 1; end
          else m_clear = 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_key_find", int'(key_find), m_kf);
      chk("model_pickup", int'(pickup), int'(m_pick));
      chk("model_stage_clear", int'(stage_clear), int'(m_clear));
      chk("model_busy", int'(busy), int'(m_cnt != 0));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // One clean rise at (x,y); returns at the cycle showing the result
  task automatic press(input int x, input int y);
    player_x = 9'(x);
    player_y = 9'(y);
    interact = 1'b0;
    tick();
    interact = 1'b1;
    tick();
    interact = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin n++; tick(); end
    if (busy) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic leave_and_return();
    state = 4'd8;
    tick();
    state = 4'd2;
  endtask

  initial begin
    int n, pk, t, x, y;
    rst_n = 1'b0; state = 4'd0; player_x = '0; player_y = '0; interact = 1'b0;
    tick(); tick();
    cmp_en = 1'b1;
    chk("rst_key_find", int'(key_find), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    state = 4'd2;

    // First pickup and cooldown length
    press(70, 40);
    chk("first_key_find", int'(key_find), 1);
    chk("first_pickup", int'(pickup), 1);
    n = 0; pk = 0;
    while (busy && n < 100) begin
      n++;
      if (pickup) pk++;
      tick();
    end
    chk("busy_cycles", n, 8);
    chk("pickup_width", pk, 1);

    // Full walk
    press(240, 40);
    chk("walk_key2", int'(key_find), 2);
    wait_idle();
    press(240, 210);
    chk("walk_key3", int'(key_find), 3);
    wait_idle();
    press(150, 215);
    chk("walk_door_clear", int'(stage_clear), 1);
    chk("walk_door_kf", int'(key_find), 3);
    tick();
    chk("door_clear_width", int'(stage_clear), 0);
    wait_idle();

    // Box edges from NONE
    leave_and_return();
    tick();
    chk("reenter_kf", int'(key_find), 0);
    press(49, 20);  chk("edge_49_20", int'(key_find), 0);
    press(85, 40);  chk("edge_85_40", int'(key_find), 0);
    press(400, 40); chk("edge_400_40", int'(key_find), 0);
    press(50, 20);  chk("edge_50_20", int'(key_find), 1);
    wait_idle();

    // Held button gives one pickup
    leave_and_return();
    player_x = 9'd70; player_y = 9'd40;
    tick();
    interact = 1'b1;
    pk = 0;
    for (int i = 0; i < 50; i++) begin tick(); if (pickup) pk++; end
    interact = 1'b0;
    chk("held_pickups", pk, 1);
    chk("held_kf", int'(key_find), 1);

    // Rise during busy is ignored
    leave_and_return();
    press(70, 40);
    chk("busy_setup_kf", int'(key_find), 1);
    press(240, 40);
    chk("busy_ignored_kf", int'(key_find), 1);
    chk("busy_still_high", int'(busy), 1);

    // Leaving STAGE1 discards progress
    wait_idle();
    press(240, 40);
    chk("leave_setup_kf", int'(key_find), 2);
    state = 4'd8;
    tick();
    chk("leave_kf", int'(key_find), 0);
    chk("leave_busy", int'(busy), 0);
    state = 4'd2;
    press(240, 40); chk("return_key2_rej", int'(key_find), 0);
    press(70, 40);  chk("return_key1_acc", int'(key_find), 1);

    // Reset mid-stage
    wait_idle();
    press(240, 40);
    wait_idle();
    press(240, 210);
    chk("pre_rst_kf", int'(key_find), 3);
    chk("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("post_rst_kf", int'(key_find), 0);
    chk("post_rst_pickup", int'(pickup), 0);
    chk("post_rst_clear", int'(stage_clear), 0);
    chk("post_rst_busy", int'(busy), 0);

    // Random walk around the targets
    for (int i = 0; i < 4000; i++) begin
      t = ($urandom % 4 == 0) ? int'($urandom % 4) : m_kf;
      x = bx0[t] - 25 + int'($urandom_range(0, 60));
      y = by0[t] - 25 + int'($urandom_range(0, 60));
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      if ($urandom % 30 == 0) x = 300 + int'($urandom % 200);
      if ($urandom % 30 == 0) y = 220 + int'($urandom % 100);
      player_x = 9'(x);
      player_y = 9'(y);
      if ($urandom % 3 == 0) interact = ~interact;
      if ($urandom % 150 == 0) state = 4'($urandom % 16);
      else if (state != 4'd2 && $urandom % 4 == 0) state = 4'd2;
      rst_n = ($urandom % 500 != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
